// File: rtl/crc16_serial_checker.sv
// Bit-serial CRC-16 checker: deserializes 50-bit codewords (34 data + 16 CRC) MSB-first
// and reports data, received CRC and pass/fail. Define CRC16_CHK_ERR_CNT_EN to build err_count.
module crc16_serial_checker #(
    parameter logic [15:0] POLY = 16'hBAAD,
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        bit_sof,
    output logic        bit_ready,
    output logic [33:0] data_out,
    output logic [15:0] crc_rx,
    output logic        crc_ok,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [7:0]  err_count
);

    localparam int unsigned CW_W   = 50;
    localparam int unsigned DATA_W = 34;
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned CNT_W  = 6;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CW_W - 1);

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW_W-1:0]     sreg;
    logic [CRC_W-1:0]    lfsr;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   data_q;
    logic [CRC_W-1:0]    crc_q;
    logic                ok_q;

    logic                beat_c;
    logic                last_beat_c;
    logic [CRC_W-1:0]    lfsr_nxt_c;
    logic [CW_W-1:0]     sreg_nxt_c;

    function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] cur, input logic b);
        logic fb;
        fb = b ^ cur[CRC_W-1];
        return {cur[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    // A SOF beat restarts the LFSR from INIT regardless of the partial frame in progress.
    always_comb begin
        beat_c      = (state == RECV) && bit_valid;
        last_beat_c = beat_c && !bit_sof && (cnt == LAST_IDX);
        lfsr_nxt_c  = lfsr_step(bit_sof ? INIT : lfsr, bit_in);
        sreg_nxt_c  = {sreg[CW_W-2:0], bit_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RECV: if (last_beat_c) state_nxt = HOLD;
            HOLD: if (result_ready) state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    always_comb begin
        bit_ready    = 1'b0;
        result_valid = 1'b0;
        case (state)
            RECV:    bit_ready    = 1'b1;
            HOLD:    result_valid = 1'b1;
            default: bit_ready    = 1'b0;
        endcase
    end

    // Shift/LFSR datapath; result fields are captured on the completing beat and held.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg   <= '0;
            lfsr   <= INIT;
            cnt    <= '0;
            data_q <= '0;
            crc_q  <= '0;
            ok_q   <= 1'b0;
        end else if (beat_c) begin
            sreg <= sreg_nxt_c;
            lfsr <= lfsr_nxt_c;
            if (bit_sof) begin
                cnt <= CNT_W'(1);
            end else if (last_beat_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (last_beat_c) begin
                data_q <= sreg_nxt_c[CW_W-1:CRC_W];
                crc_q  <= sreg_nxt_c[CRC_W-1:0];
                ok_q   <= (lfsr_nxt_c == 16'h0000);
            end
        end else if ((state == HOLD) && result_ready) begin
            lfsr <= INIT;
        end
    end

    assign data_out = data_q;
    assign crc_rx   = crc_q;
    assign crc_ok   = ok_q;

`ifdef CRC16_CHK_ERR_CNT_EN
    logic [7:0] err_q;

    // Counted when the failing frame enters HOLD, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 8'h00;
        end else if (last_beat_c && (lfsr_nxt_c != 16'h0000) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'h01;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Self-checking bench for crc16_serial_checker using a polynomial-division reference model.
module tb_crc16_serial_checker;

    localparam logic [16:0] GEN = 17'h1BAAD;
`ifdef CRC16_CHK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_sof;
    logic        bit_ready;
    logic [33:0] data_out;
    logic [15:0] crc_rx;
    logic        crc_ok;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int exp_err   = 0;

    crc16_serial_checker dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_sof      (bit_sof),
        .bit_ready    (bit_ready),
        .data_out     (data_out),
        .crc_rx       (crc_rx),
        .crc_ok       (crc_ok),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Remainder of v(x) modulo the generator over GF(2).
    function automatic logic [15:0] poly_rem(input logic [63:0] v);
        logic [63:0] r;
        r = v;
        for (int i = 63; i >= 16; i--) begin
            if (r[i]) r = r ^ (64'(GEN) << (i - 16));
        end
        return r[15:0];
    endfunction

    function automatic logic [49:0] good_cw(input logic [33:0] d);
        return {d, poly_rem(64'(d) << 16)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [49:0] cw, input bit gaps);
        for (int i = 0; i < 50; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                bit_sof   = 1'($urandom);
                @(posedge clk); #1;
            end
            check("bit_ready_recv", 64'(bit_ready), 64'(1));
            bit_in    = cw[49-i];
            bit_sof   = (i == 0);
            bit_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 0) start_cyc = cyc;
            bit_valid = 1'b0;
            bit_sof   = 1'b0;
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            bit_in    = 1'($urandom);
            bit_sof   = (i == 0);
            bit_valid = 1'b1;
            @(posedge clk); #1;
            bit_valid = 1'b0;
            bit_sof   = 1'b0;
        end
    endtask

    task automatic expect_result(input logic [49:0] cw, input int stall);
        logic ok;
        ok = (poly_rem(64'(cw)) == 16'h0000);
        if (!ok && exp_err < 255) exp_err++;
        for (int s = 0; s <= stall; s++) begin
            result_ready = (s == stall);
            check("result_valid", 64'(result_valid), 64'(1));
            check("bit_ready_hold", 64'(bit_ready), 64'(0));
            check("data_out", 64'(data_out), 64'(cw[49:16]));
            check("crc_rx", 64'(crc_rx), 64'(cw[15:0]));
            check("crc_ok", 64'(crc_ok), 64'(ok));
            check("err_count", 64'(err_count), ERR_EN ? 64'(exp_err) : 64'(0));
            @(posedge clk); #1;
        end
        check("result_valid_after", 64'(result_valid), 64'(0));
        check("bit_ready_after", 64'(bit_ready), 64'(1));
        result_ready = 1'b1;
    endtask

    initial begin
        logic [49:0] cw;
        logic [33:0] d;
        int t_a;
        reset = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        bit_sof = 1'b0;
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result_valid", 64'(result_valid), 64'(0));
        check("rst_bit_ready", 64'(bit_ready), 64'(1));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_crc_rx", 64'(crc_rx), 64'(0));
        check("rst_crc_ok", 64'(crc_ok), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        reset = 1'b0;

        // Reset mid-frame, then a clean frame.
        send_partial(20);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_err = 0;
        check("midrst_bit_ready", 64'(bit_ready), 64'(1));
        check("midrst_result_valid", 64'(result_valid), 64'(0));
        send_frame({34'h1, 16'hBAAD}, 1'b0);
        expect_result({34'h1, 16'hBAAD}, 0);

        // Reset while holding a result drops it.
        result_ready = 1'b0;
        send_frame({34'h2, 16'hCFF7}, 1'b0);
        check("hold_before_rst", 64'(result_valid), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_err = 0;
        result_ready = 1'b1;
        check("holdrst_result_valid", 64'(result_valid), 64'(0));
        check("holdrst_bit_ready", 64'(bit_ready), 64'(1));

        send_frame(50'h0, 1'b0);
        expect_result(50'h0, 0);

        // Back-to-back good frames, 51-cycle period.
        send_frame({34'h1, 16'hBAAD}, 1'b0);
        t_a = start_cyc;
        expect_result({34'h1, 16'hBAAD}, 0);
        send_frame({34'h2, 16'hCFF7}, 1'b0);
        check("frame_period", 64'(start_cyc - t_a), 64'(51));
        expect_result({34'h2, 16'hCFF7}, 0);

        send_frame({34'h1, 16'hBAAC}, 1'b0);
        expect_result({34'h1, 16'hBAAC}, 0);

        // Backpressure: handshake on the 11th HOLD cycle.
        cw = good_cw(34'h2_5A5A_A5A5);
        send_frame(cw, 1'b0);
        expect_result(cw, 10);

        // Random frames with bit_valid gaps, good or corrupted.
        for (int k = 0; k < 8; k++) begin
            d  = 34'({$urandom, $urandom});
            cw = good_cw(d);
            if ($urandom_range(0, 1) == 1) cw[15:0] = cw[15:0] ^ 16'($urandom_range(1, 16'hFFFF));
            send_frame(cw, 1'b1);
            expect_result(cw, int'($urandom_range(0, 3)));
        end

        // SOF resync after 30 beats and after 49 beats.
        send_partial(30);
        check("resync30_no_result", 64'(result_valid), 64'(0));
        send_frame({34'h2, 16'hCFF7}, 1'b0);
        expect_result({34'h2, 16'hCFF7}, 0);
        send_partial(49);
        check("resync49_no_result", 64'(result_valid), 64'(0));
        send_frame({34'h2, 16'hCFF7}, 1'b0);
        check("resync49_one_result", 64'(result_valid), 64'(1));
        expect_result({34'h2, 16'hCFF7}, 0);

        // Many bad frames drive the error count into saturation.
        for (int k = 0; k < 300; k++) begin
            d  = 34'({$urandom, $urandom});
            cw = good_cw(d);
            cw[15:0] = cw[15:0] ^ 16'($urandom_range(1, 16'hFFFF));
            send_frame(cw, 1'b0);
            expect_result(cw, 0);
        end
        check("err_saturated", 64'(err_count), ERR_EN ? 64'(255) : 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
